// File: rtl/reg8_burst_writer.sv
// Burst write sequencer for the 8x8 register file: takes a (base, len) command,
// then streams bytes into auto-incrementing addresses. Optional: REG8_BURST_CHECKSUM_EN adds csum.
module reg8_burst_writer #(
  parameter int DW = 8,
  parameter int AW = 3,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [LW-1:0] len,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          en,
  output logic [AW-1:0] wsel,
  output logic [DW-1:0] d,
  output logic          busy,
  output logic          done
`ifdef REG8_BURST_CHECKSUM_EN
  ,
  output logic [DW-1:0] csum
`endif
);

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] rem_q, rem_d;
  logic          en_q, en_d;
  logic [AW-1:0] wsel_q, wsel_d;
  logic [DW-1:0] data_q, data_d;
`ifdef REG8_BURST_CHECKSUM_EN
  logic [DW-1:0] csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      en_q    <= 1'b0;
      wsel_q  <= '0;
      data_q  <= '0;
`ifdef REG8_BURST_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      en_q    <= en_d;
      wsel_q  <= wsel_d;
      data_q  <= data_d;
`ifdef REG8_BURST_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // The last accept moves straight to DONE, so its write strobe and done coincide.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    en_d     = 1'b0;
    wsel_d   = wsel_q;
    data_d   = data_q;
    in_ready = 1'b0;
    done     = 1'b0;
`ifdef REG8_BURST_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef REG8_BURST_CHECKSUM_EN
          csum_d = '0;
`endif
          if (len != '0) begin
            addr_d  = base;
            rem_d   = len;
            state_d = BURST;
          end else begin
            state_d = DONE;
          end
        end
      end
      BURST: begin
        in_ready = 1'b1;
        if (in_valid) begin
          en_d   = 1'b1;
          wsel_d = addr_q;
          data_d = in_data;
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
`ifdef REG8_BURST_CHECKSUM_EN
          csum_d = csum_q + in_data;
`endif
          if (rem_q == LW'(1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy = (state_q != IDLE);
  assign en   = en_q;
  assign wsel = wsel_q;
  assign d    = data_q;
`ifdef REG8_BURST_CHECKSUM_EN
  assign csum = csum_q;
`endif

endmodule

// File: tb/tb_reg8_burst_writer.sv
// Directed table-driven bench for reg8_burst_writer, with hand-written
// sequences for a long wrapping burst and (when enabled) the checksum.
module tb_reg8_burst_writer;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       start = 1'b0;
  logic [2:0] base = '0;
  logic [3:0] len = '0;
  logic       inValid = 1'b0;
  logic [7:0] inData = '0;
  logic       inReady, en, busy, done;
  logic [2:0] wsel;
  logic [7:0] d;
`ifdef REG8_BURST_CHECKSUM_EN
  logic [7:0] csum;
`endif

  int vectorsApplied = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  reg8_burst_writer #(.DW(8), .AW(3), .LW(4)) dut (
    .clk(clk),
    .clr(clr),
    .start(start),
    .base(base),
    .len(len),
    .in_valid(inValid),
    .in_data(inData),
    .in_ready(inReady),
    .en(en),
    .wsel(wsel),
    .d(d),
    .busy(busy),
    .done(done)
`ifdef REG8_BURST_CHECKSUM_EN
    ,
    .csum(csum)
`endif
  );

  typedef struct {
    logic       clr;
    logic       start;
    logic [2:0] base;
    logic [3:0] len;
    logic       inValid;
    logic [7:0] inData;
    logic       expEn;
    logic [2:0] expWsel;
    logic [7:0] expD;
    logic       expBusy;
    logic       expDone;
    logic       expReady;
  } vec_t;

  localparam int NVEC = 32;
  vec_t vecs [NVEC];

  // Drive inputs, then let one rising edge go by and settle before sampling.
  task automatic applyStimulus(input logic c, input logic s, input logic [2:0] b,
                               input logic [3:0] l, input logic v, input logic [7:0] x);
    clr     = c;
    start   = s;
    base    = b;
    len     = l;
    inValid = v;
    inData  = x;
    @(posedge clk);
    #1;
  endtask

  task automatic cmpField(input string tag, input string field, input logic [7:0] act,
                          input logic [7:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", tag, field, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic eEn, input logic [2:0] eWsel,
                             input logic [7:0] eD, input logic eBusy, input logic eDone,
                             input logic eReady);
    vectorsApplied++;
    cmpField(tag, "en", 8'(en), 8'(eEn));
    cmpField(tag, "wsel", 8'(wsel), 8'(eWsel));
    cmpField(tag, "d", d, eD);
    cmpField(tag, "busy", 8'(busy), 8'(eBusy));
    cmpField(tag, "done", 8'(done), 8'(eDone));
    cmpField(tag, "in_ready", 8'(inReady), 8'(eReady));
  endtask

  initial begin
    // clr st base len iv data | en wsel d busy done ready   (outputs after the edge)
    vecs[0]  = '{1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0};
    vecs[1]  = '{1, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 1, 8'h5C, 0, 0, 8'h00, 0, 0, 0};
    // basic burst: base 2, len 3
    vecs[4]  = '{0, 1, 2, 3, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1};
    vecs[5]  = '{0, 0, 0, 0, 1, 8'h11, 1, 2, 8'h11, 1, 0, 1};
    vecs[6]  = '{0, 0, 0, 0, 1, 8'h22, 1, 3, 8'h22, 1, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 1, 8'h33, 1, 4, 8'h33, 1, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 8'h00, 0, 4, 8'h33, 0, 0, 0};
    // wrap with backpressure: base 6, len 4, valid 1,0,1,1,0,1
    vecs[9]  = '{0, 1, 6, 4, 0, 8'h00, 0, 4, 8'h33, 1, 0, 1};
    vecs[10] = '{0, 0, 0, 0, 1, 8'hA1, 1, 6, 8'hA1, 1, 0, 1};
    vecs[11] = '{0, 0, 0, 0, 0, 8'h77, 0, 6, 8'hA1, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 0, 1, 8'hB2, 1, 7, 8'hB2, 1, 0, 1};
    vecs[13] = '{0, 0, 0, 0, 1, 8'hC3, 1, 0, 8'hC3, 1, 0, 1};
    vecs[14] = '{0, 0, 0, 0, 0, 8'h00, 0, 0, 8'hC3, 1, 0, 1};
    vecs[15] = '{0, 0, 0, 0, 1, 8'hD4, 1, 1, 8'hD4, 1, 1, 0};
    vecs[16] = '{0, 0, 0, 0, 0, 8'h00, 0, 1, 8'hD4, 0, 0, 0};
    // zero length: done next cycle, no write
    vecs[17] = '{0, 1, 7, 0, 1, 8'hEE, 0, 1, 8'hD4, 1, 1, 0};
    vecs[18] = '{0, 0, 0, 0, 0, 8'h00, 0, 1, 8'hD4, 0, 0, 0};
    // start while busy: base 0 len 2, re-pulse start with base 5
    vecs[19] = '{0, 1, 0, 2, 0, 8'h00, 0, 1, 8'hD4, 1, 0, 1};
    vecs[20] = '{0, 1, 5, 7, 1, 8'h5A, 1, 0, 8'h5A, 1, 0, 1};
    vecs[21] = '{0, 1, 5, 7, 1, 8'h6B, 1, 1, 8'h6B, 1, 1, 0};
    vecs[22] = '{0, 1, 5, 2, 1, 8'h99, 0, 1, 8'h6B, 0, 0, 0};
    vecs[23] = '{0, 0, 0, 0, 0, 8'h00, 0, 1, 8'h6B, 0, 0, 0};
    // reset mid-burst: base 1 len 5, two accepts then clr
    vecs[24] = '{0, 1, 1, 5, 0, 8'h00, 0, 1, 8'h6B, 1, 0, 1};
    vecs[25] = '{0, 0, 0, 0, 1, 8'h10, 1, 1, 8'h10, 1, 0, 1};
    vecs[26] = '{0, 0, 0, 0, 1, 8'h20, 1, 2, 8'h20, 1, 0, 1};
    vecs[27] = '{1, 0, 0, 0, 1, 8'h30, 0, 0, 8'h00, 0, 0, 0};
    vecs[28] = '{0, 0, 0, 0, 1, 8'h40, 0, 0, 8'h00, 0, 0, 0};
    vecs[29] = '{0, 1, 3, 1, 0, 8'h00, 0, 0, 8'h00, 1, 0, 1};
    vecs[30] = '{0, 0, 0, 0, 1, 8'hA5, 1, 3, 8'hA5, 1, 1, 0};
    vecs[31] = '{0, 0, 0, 0, 0, 8'h00, 0, 3, 8'hA5, 0, 0, 0};

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].clr, vecs[i].start, vecs[i].base, vecs[i].len,
                    vecs[i].inValid, vecs[i].inData);
      checkOutput($sformatf("vec%0d", i), vecs[i].expEn, vecs[i].expWsel, vecs[i].expD,
                  vecs[i].expBusy, vecs[i].expDone, vecs[i].expReady);
    end

    // Longest burst: len 15 from base 5 wraps almost twice at full throughput.
    applyStimulus(0, 1, 5, 15, 0, 8'h00);
    checkOutput("long_start", 0, 3, 8'hA5, 1, 0, 1);
    for (int i = 0; i < 15; i++) begin
      logic [7:0] b;
      logic [2:0] a;
      b = 8'(i * 7 + 3);
      a = 3'((5 + i) % 8);
      applyStimulus(0, 0, 0, 0, 1, b);
      checkOutput($sformatf("long_beat%0d", i), 1, a, b, 1, (i == 14), (i != 14));
    end
    applyStimulus(0, 0, 0, 0, 0, 8'h00);
    checkOutput("long_idle", 0, 3'((5 + 14) % 8), 8'(14 * 7 + 3), 0, 0, 0);

`ifdef REG8_BURST_CHECKSUM_EN
    applyStimulus(0, 1, 0, 3, 0, 8'h00);
    vectorsApplied++;
    cmpField("csum_clear", "csum", csum, 8'h00);
    applyStimulus(0, 0, 0, 0, 1, 8'hFF);
    applyStimulus(0, 0, 0, 0, 1, 8'h02);
    applyStimulus(0, 0, 0, 0, 1, 8'h10);
    checkOutput("csum_last", 1, 2, 8'h10, 1, 1, 0);
    vectorsApplied++;
    cmpField("csum_done", "csum", csum, 8'h11);
    applyStimulus(0, 0, 0, 0, 0, 8'h00);
    vectorsApplied++;
    cmpField("csum_hold", "csum", csum, 8'h11);
    applyStimulus(0, 1, 4, 2, 0, 8'h00);
    vectorsApplied++;
    cmpField("csum_restart", "csum", csum, 8'h00);
    applyStimulus(1, 0, 0, 0, 0, 8'h00);
    vectorsApplied++;
    cmpField("csum_reset", "csum", csum, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
